// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - Access encodings, FSM states and strobe/alignment helpers for mem_stage
package mem_pkg;

    localparam int STRB_WIDTH = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    function automatic logic [STRB_WIDTH-1:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Byte-offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - Lane shift, size truncation and sign/zero extension of load data
module load_align
    import mem_pkg::*;
#(
    parameter int BUS_WIDTH = 64
) (
    input  logic [BUS_WIDTH-1:0] i_rdata,
    input  logic [2:0]           i_offset,
    input  logic [2:0]           i_funct3,
    output logic [5:0]           o_shamt,
    output logic [BUS_WIDTH-1:0] o_load_data
);

    logic [BUS_WIDTH-1:0] w_shifted;

    assign o_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_rdata >> o_shamt;

    always_comb begin
        o_load_data = w_shifted;
        case (i_funct3)
            F3_B:    o_load_data = {{(BUS_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_load_data = {{(BUS_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_data = {{(BUS_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
            F3_D:    o_load_data = w_shifted;
            F3_BU:   o_load_data = {{(BUS_WIDTH-8){1'b0}}, w_shifted[7:0]};
            F3_HU:   o_load_data = {{(BUS_WIDTH-16){1'b0}}, w_shifted[15:0]};
            F3_WU:   o_load_data = {{(BUS_WIDTH-32){1'b0}}, w_shifted[31:0]};
            default: o_load_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Pipeline memory-access stage: dmem req/ack loads and stores, writeback forwarding
// MEM_MISALIGN_TRAP_EN: misaligned accesses trap via misalign_exc instead of being aligned down.
module mem_stage
    import mem_pkg::*;
#(
    parameter int BUS_WIDTH      = 64,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [BUS_WIDTH-1:0]      alu_fpu_result,
    input  logic [BUS_WIDTH-1:0]      store_data,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      reg_write,
    output logic                      stall_out,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [BUS_WIDTH-1:0]      dmem_addr,
    output logic [BUS_WIDTH-1:0]      dmem_wdata,
    output logic [STRB_WIDTH-1:0]     dmem_wstrb,
    input  logic                      dmem_ack,
    input  logic [BUS_WIDTH-1:0]      dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      misalign_exc,
`endif
    output logic                      valid_out,
    output logic [BUS_WIDTH-1:0]      wb_data,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      reg_write_out
);

    state_e r_state;
    state_e w_next_state;

    logic                      r_valid_out;
    logic [BUS_WIDTH-1:0]      r_wb_data;
    logic [REG_ADDR_WIDTH-1:0] r_rd_out;
    logic                      r_reg_write_out;
    logic                      r_dmem_req;
    logic                      r_dmem_we;
    logic [BUS_WIDTH-1:0]      r_dmem_addr;
    logic [BUS_WIDTH-1:0]      r_dmem_wdata;
    logic [STRB_WIDTH-1:0]     r_dmem_wstrb;

    logic [2:0]                r_off;
    logic [FUNCT3_WIDTH-1:0]   r_f3;
    logic                      r_is_load;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_reg_write;

    logic                      w_accept;
    logic                      w_is_mem;
    logic                      w_issue;
    logic                      w_ack_done;
    logic [2:0]                w_amask;
    logic [2:0]                w_eff_off;
    logic [2:0]                w_al_off;
    logic [FUNCT3_WIDTH-1:0]   w_al_f3;
    logic [5:0]                w_shamt;
    logic [BUS_WIDTH-1:0]      w_load_data;

    assign w_accept   = valid_in && (r_state == IDLE);
    assign w_is_mem   = mem_read || mem_write;
    assign w_ack_done = (r_state == WAIT) && dmem_ack;
    assign w_amask    = align_mask(funct3[1:0]);
    assign w_eff_off  = alu_fpu_result[2:0] & ~w_amask;

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign_exc;
    logic w_misalign;
    assign w_misalign   = |(alu_fpu_result[2:0] & w_amask);
    assign w_issue      = w_accept && w_is_mem && !w_misalign;
    assign misalign_exc = r_misalign_exc;
`else
    assign w_issue      = w_accept && w_is_mem;
`endif

    // One aligner serves both paths: store lane shift at accept, load extraction at ack.
    assign w_al_off = (r_state == WAIT) ? r_off : w_eff_off;
    assign w_al_f3  = (r_state == WAIT) ? r_f3  : funct3;

    load_align #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_load_align (
        .i_rdata     (dmem_rdata),
        .i_offset    (w_al_off),
        .i_funct3    (w_al_f3),
        .o_shamt     (w_shamt),
        .o_load_data (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_next_state = WAIT;
            WAIT:    if (dmem_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out     <= 1'b0;
            r_wb_data       <= '0;
            r_rd_out        <= '0;
            r_reg_write_out <= 1'b0;
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= '0;
            r_dmem_wdata    <= '0;
            r_dmem_wstrb    <= '0;
            r_off           <= '0;
            r_f3            <= '0;
            r_is_load       <= 1'b0;
            r_rd            <= '0;
            r_reg_write     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign_exc  <= 1'b0;
`endif
        end else begin
            r_valid_out <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign_exc <= 1'b0;
            if (w_accept && w_is_mem && w_misalign) begin
                r_misalign_exc  <= 1'b1;
                r_valid_out     <= 1'b1;
                r_wb_data       <= alu_fpu_result;
                r_rd_out        <= rd;
                r_reg_write_out <= 1'b0;
            end
`endif
            if (w_accept && !w_is_mem) begin
                r_valid_out     <= 1'b1;
                r_wb_data       <= alu_fpu_result;
                r_rd_out        <= rd;
                r_reg_write_out <= reg_write;
            end
            if (w_issue) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= mem_write;
                r_dmem_addr  <= {alu_fpu_result[BUS_WIDTH-1:3], 3'b000};
                r_dmem_wdata <= store_data << w_shamt;
                r_dmem_wstrb <= mem_write ? (size_mask(funct3[1:0]) << w_eff_off) : '0;
                r_off        <= w_eff_off;
                r_f3         <= funct3;
                r_is_load    <= mem_read;
                r_rd         <= rd;
                r_reg_write  <= reg_write;
            end
            if (w_ack_done) begin
                r_dmem_req      <= 1'b0;
                r_valid_out     <= 1'b1;
                r_rd_out        <= r_rd;
                r_reg_write_out <= r_is_load && r_reg_write;
                if (r_is_load) begin
                    r_wb_data <= w_load_data;
                end
            end
        end
    end

    assign stall_out     = (r_state == WAIT);
    assign dmem_req      = r_dmem_req;
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign dmem_wstrb    = r_dmem_wstrb;
    assign valid_out     = r_valid_out;
    assign wb_data       = r_wb_data;
    assign rd_out        = r_rd_out;
    assign reg_write_out = r_reg_write_out;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - Self-checking bench for mem_stage: vector table, corner sequences, random vs byte model
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [63:0] alu_fpu_result;
    logic [63:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        valid_out;
    logic [63:0] wb_data;
    logic [4:0]  rd_out;
    logic        reg_write_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_b [0:127];
    logic [63:0] bus_w [0:15];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        logic [63:0] e_wb;
    } vec_t;

    vec_t vt[$];

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .alu_fpu_result (alu_fpu_result),
        .store_data     (store_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .rd             (rd),
        .reg_write      (reg_write),
        .stall_out      (stall_out),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_exc   (misalign_exc),
`endif
        .valid_out      (valid_out),
        .wb_data        (wb_data),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Services one outstanding request; returns the number of WAIT cycles seen.
    task automatic run_wait(input int waits, input logic use_bus, input logic [63:0] rdata_fix,
                            output int ncyc);
        ncyc = 0;
        while (stall_out === 1'b1 && ncyc < 50) begin
            ncyc++;
            chk("req_held", dmem_req, 1);
            dmem_ack = (ncyc > waits);
            if (use_bus) begin
                dmem_rdata = bus_w[dmem_addr[6:3]];
                if (dmem_ack && dmem_we)
                    for (int j = 0; j < 8; j++)
                        if (dmem_wstrb[j]) bus_w[dmem_addr[6:3]][8*j +: 8] = dmem_wdata[8*j +: 8];
            end else begin
                dmem_rdata = rdata_fix;
            end
            tick;
        end
        dmem_ack = 1'b0;
        chk("wait_bound", 64'(ncyc < 50), 1);
    endtask

    initial begin
        int          ncyc;
        int          kind;
        int          n;
        int          eai;
        logic [63:0] a;
        logic [63:0] sd;
        logic [63:0] nm;
        logic [63:0] exp_v;
        logic [2:0]  f3;
        logic [4:0]  r;
        logic        rw;
        logic [63:0] word;

        vt.push_back(vec_t'{1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 64'h1000, 8'h00, 64'h0, 64'h0000_0000_0000_0080});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b001, 64'h10,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h10,   8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_9687});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b101, 64'h16,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h10,   8'h00, 64'h0, 64'h0000_0000_0000_F0E1});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b010, 64'h24,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h20,   8'h00, 64'h0, 64'hFFFF_FFFF_F0E1_D2C3});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b110, 64'h20,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h20,   8'h00, 64'h0, 64'h0000_0000_B4A5_9687});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b011, 64'h38,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h38,   8'h00, 64'h0, 64'hF0E1_D2C3_B4A5_9687});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b111, 64'h40,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h40,   8'h00, 64'h0, 64'hF0E1_D2C3_B4A5_9687});
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b000, 64'h45,   64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h40,   8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFD2});
        vt.push_back(vec_t'{1'b0, 1'b1, 3'b001, 64'h2006, 64'h1122_3344_5566_BEEF, 64'h0, 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0});
        vt.push_back(vec_t'{1'b0, 1'b1, 3'b000, 64'h2001, 64'h1122_3344_5566_BEEF, 64'h0, 64'h2000, 8'h02, 64'h2233_4455_66BE_EF00, 64'h0});
        vt.push_back(vec_t'{1'b0, 1'b1, 3'b010, 64'h2004, 64'h1122_3344_5566_BEEF, 64'h0, 64'h2000, 8'hF0, 64'h5566_BEEF_0000_0000, 64'h0});
        vt.push_back(vec_t'{1'b0, 1'b1, 3'b011, 64'h2008, 64'h1122_3344_5566_BEEF, 64'h0, 64'h2008, 8'hFF, 64'h1122_3344_5566_BEEF, 64'h0});
`ifndef MEM_MISALIGN_TRAP_EN
        vt.push_back(vec_t'{1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 64'h3000, 8'h00, 64'h0, 64'hFFFF_FFFF_B4A5_9687});
`endif

        for (int i = 0; i < 16; i++) begin
            bus_w[i] = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) mem_b[8*i+j] = bus_w[i][8*j +: 8];
        end

        rst_n = 1'b0; valid_in = 1'b0; alu_fpu_result = '0; store_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; rd = '0; reg_write = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        tick; tick;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wstrb", dmem_wstrb, 0);
        chk("rst_wb", wb_data, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_rw_out", reg_write_out, 0);
        rst_n = 1'b1;
        tick;

        // ALU packets back to back, one per cycle
        valid_in = 1'b1; alu_fpu_result = 64'h1234; rd = 5'd7; reg_write = 1'b1;
        tick;
        chk("alu_valid", valid_out, 1);
        chk("alu_wb", wb_data, 64'h1234);
        chk("alu_rd", rd_out, 7);
        chk("alu_rw", reg_write_out, 1);
        chk("alu_stall", stall_out, 0);
        alu_fpu_result = 64'hABCD; rd = 5'd9; reg_write = 1'b0;
        tick;
        valid_in = 1'b0;
        chk("alu2_valid", valid_out, 1);
        chk("alu2_wb", wb_data, 64'hABCD);
        chk("alu2_rw", reg_write_out, 0);
        chk("alu2_stall", stall_out, 0);
        tick;
        chk("alu_pulse", valid_out, 0);

        // Stray ack with no request outstanding
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        chk("stray_ack_valid", valid_out, 0);
        chk("stray_ack_stall", stall_out, 0);

        // Table vectors
        foreach (vt[i]) begin
            valid_in = 1'b1; mem_read = vt[i].rd; mem_write = vt[i].wr; funct3 = vt[i].f3;
            alu_fpu_result = vt[i].addr; store_data = vt[i].sdata; rd = 5'(i); reg_write = 1'b1;
            tick;
            valid_in = 1'b0;
            chk("vec_req", dmem_req, 1);
            chk("vec_stall", stall_out, 1);
            chk("vec_addr", dmem_addr, vt[i].e_addr);
            chk("vec_we", dmem_we, vt[i].wr);
            chk("vec_wstrb", dmem_wstrb, vt[i].e_strb);
            if (vt[i].wr) chk("vec_wdata", dmem_wdata, vt[i].e_wdata);
            run_wait(i % 3, 1'b0, vt[i].rdata, ncyc);
            chk("vec_wait_cycles", ncyc, (i % 3) + 1);
            chk("vec_valid", valid_out, 1);
            chk("vec_req_drop", dmem_req, 0);
            if (vt[i].rd) chk("vec_wb", wb_data, vt[i].e_wb);
            chk("vec_rw", reg_write_out, vt[i].rd);
            chk("vec_rd", rd_out, 5'(i));
            tick;
            chk("vec_pulse", valid_out, 0);
        end
        mem_read = 1'b0; mem_write = 1'b0;

        // LD then ALU, ack in the first WAIT cycle
        valid_in = 1'b1; mem_read = 1'b1; funct3 = 3'b011; alu_fpu_result = 64'h38; rd = 5'd3; reg_write = 1'b1;
        tick;
        mem_read = 1'b0; alu_fpu_result = 64'h55; rd = 5'd4;
        dmem_ack = 1'b1; dmem_rdata = 64'h0123_4567_89AB_CDEF;
        chk("b2b_stall", stall_out, 1);
        tick;
        dmem_ack = 1'b0;
        chk("b2b_ld_valid", valid_out, 1);
        chk("b2b_ld_wb", wb_data, 64'h0123_4567_89AB_CDEF);
        chk("b2b_ld_rd", rd_out, 3);
        chk("b2b_stall_drop", stall_out, 0);
        tick;
        valid_in = 1'b0;
        chk("b2b_alu_valid", valid_out, 1);
        chk("b2b_alu_wb", wb_data, 64'h55);
        chk("b2b_alu_rd", rd_out, 4);
        tick;
        chk("b2b_pulse", valid_out, 0);

        // Reset during WAIT, then a late ack
        valid_in = 1'b1; mem_read = 1'b1; funct3 = 3'b011; alu_fpu_result = 64'h48; rd = 5'd6;
        tick;
        valid_in = 1'b0; mem_read = 1'b0;
        chk("rw_req_before", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_req_async", dmem_req, 0);
        chk("rw_stall_async", stall_out, 0);
        dmem_ack = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        chk("rw_late_ack_valid", valid_out, 0);
        tick;
        chk("rw_late_ack_valid2", valid_out, 0);
        chk("rw_late_ack_req", dmem_req, 0);
        dmem_ack = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
        valid_in = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_fpu_result = 64'h3002; rd = 5'd8; reg_write = 1'b1;
        tick;
        valid_in = 1'b0; mem_read = 1'b0;
        chk("mis_req", dmem_req, 0);
        chk("mis_stall", stall_out, 0);
        chk("mis_exc", misalign_exc, 1);
        chk("mis_valid", valid_out, 1);
        chk("mis_rw", reg_write_out, 0);
        chk("mis_wb", wb_data, 64'h3002);
        tick;
        chk("mis_exc_pulse", misalign_exc, 0);
        chk("mis_valid_pulse", valid_out, 0);
`endif

        // Random traffic against a byte-addressed reference memory
        for (int p = 0; p < 200; p++) begin
            kind = $urandom_range(0, 2);
            r  = 5'($urandom);
            rw = 1'($urandom);
            valid_in = 1'b1; rd = r; reg_write = rw; mem_read = 1'b0; mem_write = 1'b0;
            if (kind == 0) begin
                a = {$urandom, $urandom};
                alu_fpu_result = a;
                tick;
                valid_in = 1'b0;
                chk("rnd_alu_valid", valid_out, 1);
                chk("rnd_alu_wb", wb_data, a);
                chk("rnd_alu_rd", rd_out, r);
                chk("rnd_alu_rw", reg_write_out, rw);
            end else begin
                f3 = (kind == 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                n  = 1 << f3[1:0];
                nm = 64'(n);
                a  = 64'($urandom_range(0, 127));
`ifdef MEM_MISALIGN_TRAP_EN
                a = a & ~(nm - 1);
`endif
                eai = int'(a & ~(nm - 1));
                sd  = {$urandom, $urandom};
                mem_read = (kind == 1); mem_write = (kind == 2); funct3 = f3;
                alu_fpu_result = a; store_data = sd;
                tick;
                valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
                chk("rnd_addr", dmem_addr, a & ~64'h7);
                chk("rnd_we", dmem_we, kind == 2);
                run_wait($urandom_range(0, 3), 1'b1, 64'h0, ncyc);
                chk("rnd_valid", valid_out, 1);
                chk("rnd_rd", rd_out, r);
                if (kind == 1) begin
                    exp_v = '0;
                    for (int k = 0; k < n; k++) exp_v = exp_v | (64'(mem_b[eai+k]) << (8*k));
                    if (!f3[2] && n < 8 && exp_v[8*n-1]) exp_v = exp_v | ~((64'd1 << (8*n)) - 1);
                    chk("rnd_load", wb_data, exp_v);
                    chk("rnd_load_rw", reg_write_out, rw);
                end else begin
                    for (int k = 0; k < n; k++) mem_b[eai+k] = sd[8*k +: 8];
                    chk("rnd_store_rw", reg_write_out, 0);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                tick;
                chk("rnd_gap_valid", valid_out, 0);
            end
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 8; j++) word[8*j +: 8] = mem_b[8*i+j];
            chk("mem_word", bus_w[i], word);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
